// File: rtl/game_round_pkg.sv
// Purpose: shared types and constants for the game round controller blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package game_round_pkg;

    // Round sequencing states; IDLE is the reset state.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        TARGET_RUN  = 3'd2,
        TORPEDO_RUN = 3'd3,
        PAUSE       = 3'd4
    } round_state_t;

    // Number of strobes spent in the end-of-round pause (legal 1..255).
    localparam int END_PAUSE_STROBES_DEFAULT = 64;

    // Width of the won-rounds score counter.
    localparam int SCORE_W = 8;

    // Free-running strobe counter width: one strobe per 2^width clocks.
    localparam int STROBE_CNT_W_DEFAULT = 20;

endpackage

// File: rtl/game_strobe_gen.sv
// Purpose: free-running wrap-around counter emitting a 1-cycle frame strobe when it reads 0.
// Latency: strobe_o is a decode of the counter register; pre_strobe_o leads it by one cycle.
// Backpressure: none; the counter never stalls and ignores the rest of the design.
module game_strobe_gen #(
    parameter int W = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic strobe_o,
    output logic pre_strobe_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count simply wraps modulo 2^W.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Counter register; only reset restarts it, never any state change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_o     = (cnt_q == '0);
    // All-ones means the counter reads 0 next cycle: lets users register strobe-aligned pulses.
    assign pre_strobe_o = (cnt_q == '1);

endmodule

// File: rtl/game_round_sequencer.sv
// Purpose: round FSM (idle/load/target/torpedo/pause) gating sprite updates; score built only with GAME_ROUND_SCORE_EN.
// Latency: launch edge -> state change 2 cycles; collision/out -> end_of_round/round_won 1 cycle; all outputs registered.
// Backpressure: none; inputs are levels sampled every cycle, launch edges during LOAD/PAUSE are dropped.
module game_round_sequencer
    import game_round_pkg::*;
#(
    parameter int strobe_to_update_xy_counter_width = STROBE_CNT_W_DEFAULT,
    parameter int end_pause_strobes                 = END_PAUSE_STROBES_DEFAULT,
    parameter int w_score                           = SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               launch_key,
    input  logic               collision,
    input  logic               target_out,
    input  logic               torpedo_out,
    output logic               sprite_write_xy,
    output logic               target_update,
    output logic               torpedo_update,
    output logic               torpedo_visible,
    output logic               end_of_round,
    output logic               round_won,
    output logic [w_score-1:0] score
);

    localparam logic [7:0] PAUSE_LOAD = 8'(end_pause_strobes);

    logic strobe;
    logic pre_strobe;

    game_strobe_gen #(
        .W (strobe_to_update_xy_counter_width)
    ) u_strobe (
        .clk_i        (clk),
        .rst_i        (rst),
        .strobe_o     (strobe),
        .pre_strobe_o (pre_strobe)
    );

    logic launch_q;
    logic launch_edge_q;

    // Launch rising-edge detect; the edge is presented one cycle after the key rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            launch_q      <= 1'b0;
            launch_edge_q <= 1'b0;
        end else begin
            launch_q      <= launch_key;
            launch_edge_q <= launch_key & ~launch_q;
        end
    end

    round_state_t state_q, state_d;
    logic [7:0]   pause_q, pause_d;
    logic         round_won_q, round_won_d;
    logic         sprite_write_q, sprite_write_d;
    logic         target_update_q, target_update_d;
    logic         torpedo_update_q, torpedo_update_d;
    logic         torpedo_visible_q, torpedo_visible_d;
    logic         end_of_round_q, end_of_round_d;

    // Next-state, pause counter and result; outputs decode the next state so they line up with it.
    always_comb begin
        state_d     = state_q;
        pause_d     = pause_q;
        round_won_d = round_won_q;
        unique case (state_q)
            IDLE: begin
                if (launch_edge_q) begin
                    state_d     = LOAD;
                    round_won_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = TARGET_RUN;
            end
            TARGET_RUN: begin
                // Torpedo not launched yet: only the target leaving ends the round.
                if (target_out) begin
                    state_d     = PAUSE;
                    pause_d     = PAUSE_LOAD;
                    round_won_d = 1'b0;
                end else if (launch_edge_q) begin
                    state_d = TORPEDO_RUN;
                end
            end
            TORPEDO_RUN: begin
                if (collision) begin
                    state_d     = PAUSE;
                    pause_d     = PAUSE_LOAD;
                    round_won_d = 1'b1;
                end else if (target_out || torpedo_out) begin
                    state_d     = PAUSE;
                    pause_d     = PAUSE_LOAD;
                    round_won_d = 1'b0;
                end
            end
            PAUSE: begin
                if (strobe) begin
                    if (pause_q <= 8'd1) begin
                        state_d = IDLE;
                        pause_d = 8'd0;
                    end else begin
                        pause_d = pause_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sprite_write_d    = (state_d == LOAD);
        target_update_d   = pre_strobe && ((state_d == TARGET_RUN) || (state_d == TORPEDO_RUN));
        torpedo_update_d  = pre_strobe && (state_d == TORPEDO_RUN);
        torpedo_visible_d = (state_d == TORPEDO_RUN);
        end_of_round_d    = (state_d == PAUSE);
    end

    // State, pause counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            pause_q           <= 8'd0;
            round_won_q       <= 1'b0;
            sprite_write_q    <= 1'b0;
            target_update_q   <= 1'b0;
            torpedo_update_q  <= 1'b0;
            torpedo_visible_q <= 1'b0;
            end_of_round_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            pause_q           <= pause_d;
            round_won_q       <= round_won_d;
            sprite_write_q    <= sprite_write_d;
            target_update_q   <= target_update_d;
            torpedo_update_q  <= torpedo_update_d;
            torpedo_visible_q <= torpedo_visible_d;
            end_of_round_q    <= end_of_round_d;
        end
    end

    assign sprite_write_xy = sprite_write_q;
    assign target_update   = target_update_q;
    assign torpedo_update  = torpedo_update_q;
    assign torpedo_visible = torpedo_visible_q;
    assign end_of_round    = end_of_round_q;
    assign round_won       = round_won_q;

`ifdef GAME_ROUND_SCORE_EN
    logic               win_evt;
    logic [w_score-1:0] score_q, score_d;

    // A win is exactly the collision branch out of TORPEDO_RUN.
    assign win_evt = (state_q == TORPEDO_RUN) && collision;

    // Saturating increment of the won-rounds count.
    always_comb begin
        score_d = score_q;
        if (win_evt && (score_q != '1)) begin
            score_d = score_q + 1'b1;
        end
    end

    // Score register, cleared by reset only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_game_round_sequencer.sv
// Purpose: directed self-checking bench for game_round_sequencer (small strobe counter, 2-bit score).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_game_round_sequencer;

    localparam int CW = 3;
    localparam int NP = 64;
    localparam int WS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          launch_key = 1'b0;
    logic          collision = 1'b0;
    logic          target_out = 1'b0;
    logic          torpedo_out = 1'b0;
    logic          sprite_write_xy;
    logic          target_update;
    logic          torpedo_update;
    logic          torpedo_visible;
    logic          end_of_round;
    logic          round_won;
    logic [WS-1:0] score;

    int checks = 0;
    int failures = 0;
    int wins = 0;
    int tick;
    logic strobe_m;

    game_round_sequencer #(
        .strobe_to_update_xy_counter_width (CW),
        .end_pause_strobes                 (NP),
        .w_score                           (WS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .launch_key      (launch_key),
        .collision       (collision),
        .target_out      (target_out),
        .torpedo_out     (torpedo_out),
        .sprite_write_xy (sprite_write_xy),
        .target_update   (target_update),
        .torpedo_update  (torpedo_update),
        .torpedo_visible (torpedo_visible),
        .end_of_round    (end_of_round),
        .round_won       (round_won),
        .score           (score)
    );

    always #5 clk = ~clk;

    // Reference strobe: cycles since reset release, strobe every 2^CW cycles starting at 0.
    always @(posedge clk or posedge rst) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end
    assign strobe_m = ((tick % (1 << CW)) == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_score();
`ifdef GAME_ROUND_SCORE_EN
        return (wins > 3) ? 3 : wins;
`else
        return 0;
`endif
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sprite"}, 32'(sprite_write_xy), 0);
        check({tag, "_tupd"},   32'(target_update), 0);
        check({tag, "_pupd"},   32'(torpedo_update), 0);
        check({tag, "_vis"},    32'(torpedo_visible), 0);
        check({tag, "_eor"},    32'(end_of_round), 0);
        check({tag, "_won"},    32'(round_won), 0);
        check({tag, "_score"},  32'(score), 0);
    endtask

    // Launch from IDLE: sprite load pulse must appear exactly at edge+2.
    task automatic do_load();
        next_cyc(); launch_key = 1'b1;
        sample();   check("sprite_n0", 32'(sprite_write_xy), 0);
        next_cyc(); launch_key = 1'b0;
        sample();   check("sprite_n1", 32'(sprite_write_xy), 0);
        next_cyc();
        sample();   check("sprite_n2", 32'(sprite_write_xy), 1);
                    check("won_clr_load", 32'(round_won), 0);
        next_cyc();
        sample();   check("sprite_n3", 32'(sprite_write_xy), 0);
    endtask

    // Launch the torpedo from TARGET_RUN: visible from edge+2.
    task automatic fire_torpedo();
        next_cyc(); launch_key = 1'b1;
        sample();   check("vis_n0", 32'(torpedo_visible), 0);
        next_cyc(); launch_key = 1'b0;
        sample();   check("vis_n1", 32'(torpedo_visible), 0);
        next_cyc();
        sample();   check("vis_n2", 32'(torpedo_visible), 1);
    endtask

    task automatic run_window(input int n, input logic torp);
        for (int i = 0; i < n; i++) begin
            next_cyc();
            sample();
            check("tgt_upd", 32'(target_update), 32'(strobe_m));
            check("trp_upd", 32'(torpedo_update), 32'(torp & strobe_m));
        end
    endtask

    // End-of-round event; lk raises launch one cycle early so its edge coincides with the event.
    task automatic end_evt(input logic c, input logic to, input logic po, input logic lk,
                           input logic exp_won);
        if (lk) begin
            next_cyc(); launch_key = 1'b1;
        end
        next_cyc();
        collision = c; target_out = to; torpedo_out = po; launch_key = 1'b0;
        sample();
        check("eor_at_n", 32'(end_of_round), 0);
        next_cyc();
        collision = 1'b0; target_out = 1'b0; torpedo_out = 1'b0;
        sample();
        check("eor_n1",   32'(end_of_round), 1);
        check("won_n1",   32'(round_won), 32'(exp_won));
        check("score_n1", 32'(score), 32'(exp_score()));
        check("vis_pause", 32'(torpedo_visible), 0);
        check("tupd_pause", 32'(target_update), 0);
        check("pupd_pause", 32'(torpedo_update), 0);
    endtask

    // Count strobes while end_of_round is high; optionally pulse launch mid-pause.
    task automatic wait_pause(input logic poke, input logic exp_won);
        int   n_str = 0;
        int   i = 0;
        logic last = 1'b0;
        logic done = 1'b0;
        while (!done && (i < 3000)) begin
            if (end_of_round) begin
                if (strobe_m) n_str++;
                last = strobe_m;
                if (poke && (i == 10)) launch_key = 1'b1;
                if (poke && (i == 12)) launch_key = 1'b0;
                next_cyc();
                sample();
                i++;
            end else begin
                done = 1'b1;
            end
        end
        check("pause_done", 32'(done), 1);
        check("pause_strobes", 32'(n_str), 32'(NP));
        check("pause_exit_after_strobe", 32'(last), 1);
        check("won_hold_idle", 32'(round_won), 32'(exp_won));
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            sample();
            check("idle_sprite", 32'(sprite_write_xy), 0);
            check("idle_eor", 32'(end_of_round), 0);
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        next_cyc();
        sample();
        check("idle_no_sprite", 32'(sprite_write_xy), 0);

        // Round 1: target run, torpedo run, collision -> won.
        do_load();
        run_window(20, 1'b0);
        fire_torpedo();
        run_window(16, 1'b1);
        wins++;
        end_evt(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_pause(1'b0, 1'b1);

        // Round 2: target_out with coincident launch edge in TARGET_RUN -> lost; launch in pause ignored.
        do_load();
        run_window(5, 1'b0);
        end_evt(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_pause(1'b1, 1'b0);

        // Round 3: torpedo_out in TORPEDO_RUN -> lost.
        do_load();
        fire_torpedo();
        run_window(3, 1'b1);
        end_evt(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_pause(1'b0, 1'b0);

        // Round 4: collision + torpedo_out + launch edge together -> won.
        do_load();
        fire_torpedo();
        wins++;
        end_evt(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_pause(1'b0, 1'b1);

        // Rounds 5..7: further wins, score saturates at 3.
        for (int r = 0; r < 3; r++) begin
            do_load();
            fire_torpedo();
            wins++;
            end_evt(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            wait_pause(1'b0, 1'b1);
        end

        // Mid-round reset: outputs clear before any clock edge.
        do_load();
        fire_torpedo();
        run_window(4, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        next_cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            sample();
            check("post_rst_vis", 32'(torpedo_visible), 0);
            check("post_rst_sprite", 32'(sprite_write_xy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
